radix4_mult_arbiter: RTL and testbench
======================================

// Module: radix4_mult_arbiter
// PURPOSE
//   Shares one radix-4 8x8 multiplier core between NREQ requesters.
//   Round-robin arbitration picks a requester and captures its A/B bytes.
//   The block drives the core's byte-serial getA/getB/start/putOut protocol, waits for done,
//   and returns the 16-bit product with the requester id over a valid/ready response port.
//   It sits between the client logic and the multiplier top level, and replaces manual key/switch sequencing.
// PARAMETERS
//   NREQ      2    number of requesters (2..8)
//   RES_LAT   1    cycles from putOut pulse to m_res valid (1..3)
//   WDOG_CYC  64   watchdog limit in cycles for done after start (only with MULT_WDOG_EN)
// PORTS
//   clk        in   1         clock, rising edge
//   rst        in   1         reset, asynchronous, active-low
//   req_valid  in   NREQ      per-requester request valid
//   req_a      in   NREQ*8    operand A bytes, requester i at [8i+7:8i]
//   req_b      in   NREQ*8    operand B bytes, same packing
//   req_ready  out  NREQ      one-hot grant; 1-cycle pulse when operands are captured
//   rsp_valid  out  1         response valid; held until rsp_ready
//   rsp_ready  in   1         response accepted
//   rsp_id     out  $clog2(NREQ)  index of the granted requester
//   rsp_res    out  16        product A*B, unsigned
//   rsp_err    out  1         watchdog abort; rsp_res=0 (always 0 without MULT_WDOG_EN)
//   busy       out  1         high in every state except IDLE
//   m_in       out  8         byte bus to the multiplier core
//   m_getA, m_getB, m_start, m_putOut  out 1 each  1-cycle strobes to the core
//   m_done     in   1         level; core finished
//   m_res      in   16        core product
// BEHAVIOUR
//   Reset (rst=0, asynchronous): all outputs 0, FSM=IDLE, rr pointer=NREQ-1.
//   Reset mid-operation aborts without a response. The core shares rst.
//   FSM, one state per cycle unless noted:
//     IDLE  : if any req_valid, grant, pulse req_ready[g], latch A/B/id -> LDA
//     LDA   : m_in=A, m_getA=1 -> LDB
//     LDB   : m_in=B, m_getB=1 -> STRT
//     STRT  : m_start=1, clear watchdog counter -> WAIT
//     WAIT  : stay until m_done=1 -> PUT
//     PUT   : m_putOut=1 -> LAT; wait RES_LAT cycles, then latch m_res -> RSP
//     RSP   : rsp_valid=1 until rsp_ready; handshake cycle -> IDLE
//   Grant to first response = 4+RES_LAT cycles plus core time. No back-to-back grant.
//   IDLE is re-entered for one cycle before the next grant.
//   Round-robin: search starts at pointer+1 modulo NREQ, and the first valid wins.
//     Pointer := g on grant. With all requesters valid, grants rotate 0,1,..,NREQ-1.
//   req_valid dropping after grant is ignored; operands were already captured.
//   m_in=0 outside LDA/LDB. m_done in any state other than WAIT is ignored.
//   rsp_* stable while rsp_valid && !rsp_ready. Width rule: rsp_res = m_res verbatim, no sign extension.
// CONFIGURATION
//   MULT_WDOG_EN defined: a counter runs in WAIT.
//     On reaching WDOG_CYC with no m_done -> RSP with rsp_err=1, rsp_res=0.
//     If m_done and the limit coincide, done wins.
//   MULT_WDOG_EN undefined: no counter; WAIT blocks indefinitely; rsp_err tied 0.
// STRUCTURE
//   Package mult_arb_pkg: state enum (IDLE,LDA,LDB,STRT,WAIT,PUT,LAT,RSP), OPW=8, RESW=16.
//   Sub-module rr_arbiter #(NREQ): req vector + pointer -> one-hot grant + index.
//     Purely combinational; the pointer register is in the parent.
// TESTING
//   Single req0, A=8'h0C B=8'h0A -> strobes getA,getB,start in order; rsp_id=0, rsp_res=16'h0078.
//   A=8'hFF B=8'hFF -> rsp_res=16'hFE01; A=0 B=8'h5A -> 16'h0000.
//   req0,req1 valid continuously, 4 ops -> grant order 0,1,0,1; each result matches its operands.
//   rsp_ready low 5 cycles -> rsp_valid/rsp_res/rsp_id held; no new req_ready until accepted.
//   Pull rst low during WAIT -> outputs 0 immediately; after release a fresh request completes.
//   MULT_WDOG_EN, WDOG_CYC=16, m_done stuck 0 -> rsp_err=1, rsp_res=0 at cycle 16 of WAIT.

Source files
------------

// File: rtl/radix4_mult_arbiter_pkg.sv
// Shared types and constants for the radix-4 multiplier arbiter slice.
// Optional feature macro used elsewhere in the slice: MULT_WDOG_EN.
package mult_arb_pkg;

    localparam int OPW  = 8;
    localparam int RESW = 16;

    // FSM encoding is kept as plain 3-bit constants so older blocks that
    // compare against raw codes keep working.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LDA  = 3'd1;
    localparam state_t ST_LDB  = 3'd2;
    localparam state_t ST_STRT = 3'd3;
    localparam state_t ST_WAIT = 3'd4;
    localparam state_t ST_PUT  = 3'd5;
    localparam state_t ST_LAT  = 3'd6;
    localparam state_t ST_RSP  = 3'd7;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/radix4_mult_arbiter_if.sv
// Request/response bundle between client logic and the multiplier arbiter.
// master = client side, slave = arbiter side.
interface radix4_mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int IDW = idx_width(NREQ);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [RESW-1:0]     rsp_res;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err
    );

endinterface

// File: rtl/radix4_mult_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past the pointer
// and wraps, so the most recently served requester has lowest priority.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    // Scan from the farthest candidate to the nearest so the nearest valid one
    // (pointer+1 first) is the last to overwrite the result.
    always_comb begin
        int j;
        grant_any = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int off = NREQ; off >= 1; off--) begin
            j = int'(ptr) + off;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant[gi] = grant_any && (grant_idx == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/radix4_mult_arbiter.sv
// Shares one byte-serial radix-4 8x8 multiplier core between NREQ requesters.
// Optional watchdog on the core's done signal: define MULT_WDOG_EN.
module radix4_mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int RES_LAT  = 1,
    parameter int WDOG_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    radix4_mult_arbiter_if.slave  bus,
    output logic                  busy,
    output logic [OPW-1:0]        m_in,
    output logic                  m_getA,
    output logic                  m_getB,
    output logic                  m_start,
    output logic                  m_putOut,
    input  logic                  m_done,
    input  logic [RESW-1:0]       m_res
);

    localparam int IDW = idx_width(NREQ);

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic [OPW-1:0]  a_reg, b_reg;
    logic [1:0]      lat_cnt_reg;
    logic [RESW-1:0] res_reg;
    logic [NREQ-1:0] ready_reg;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            wdog_expired;
    logic            lat_last;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign lat_last = (lat_cnt_reg == 2'(RES_LAT - 1));

`ifdef MULT_WDOG_EN
    localparam int WDW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    logic [WDW-1:0] wdog_reg;
    logic           err_reg;

    assign wdog_expired = (wdog_reg == WDW'(WDOG_CYC - 1));

    // Watchdog counts WAIT cycles; flags an error only when done did not win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_STRT) begin
                wdog_reg <= '0;
                err_reg  <= 1'b0;
            end else if (state_reg == ST_WAIT && !m_done) begin
                wdog_reg <= wdog_reg + 1'b1;
                if (wdog_expired) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.rsp_err = err_reg;
`else
    assign wdog_expired = 1'b0;
    assign bus.rsp_err  = 1'b0;
`endif

    // Next-state logic; done takes priority over a simultaneous watchdog expiry.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant_any) state_next = ST_LDA;
            ST_LDA:  state_next = ST_LDB;
            ST_LDB:  state_next = ST_STRT;
            ST_STRT: state_next = ST_WAIT;
            ST_WAIT: begin
                if (m_done) begin
                    state_next = ST_PUT;
                end else if (wdog_expired) begin
                    state_next = ST_RSP;
                end
            end
            ST_PUT:  state_next = ST_LAT;
            ST_LAT:  if (lat_last) state_next = ST_RSP;
            ST_RSP:  if (bus.rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset mid-operation simply drops the transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture, round-robin pointer, result latch and grant pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg     <= IDW'(NREQ - 1);
            id_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            lat_cnt_reg <= '0;
            res_reg     <= '0;
            ready_reg   <= '0;
        end else begin
            ready_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        ready_reg <= grant;
                        ptr_reg   <= grant_idx;
                        id_reg    <= grant_idx;
                        a_reg     <= bus.req_a[grant_idx*OPW +: OPW];
                        b_reg     <= bus.req_b[grant_idx*OPW +: OPW];
                    end
                end
                ST_WAIT: begin
                    if (!m_done && wdog_expired) begin
                        res_reg <= '0;
                    end
                end
                ST_PUT: lat_cnt_reg <= '0;
                ST_LAT: begin
                    lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    if (lat_last) begin
                        res_reg <= m_res;
                    end
                end
                default: ;
            endcase
        end
    end

    // Core strobes and response outputs are decoded straight from state.
    assign busy          = (state_reg != ST_IDLE);
    assign m_getA        = (state_reg == ST_LDA);
    assign m_getB        = (state_reg == ST_LDB);
    assign m_start       = (state_reg == ST_STRT);
    assign m_putOut      = (state_reg == ST_PUT);
    assign m_in          = (state_reg == ST_LDA) ? a_reg :
                           (state_reg == ST_LDB) ? b_reg : '0;
    assign bus.req_ready = ready_reg;
    assign bus.rsp_valid = (state_reg == ST_RSP);
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_res   = res_reg;

endmodule

// File: tb/tb_radix4_mult_arbiter.sv
// Directed bench for radix4_mult_arbiter with a behavioural multiplier core.
// Watchdog case is exercised when built with MULT_WDOG_EN.
module tb_radix4_mult_arbiter;

    localparam int NREQ    = 2;
    localparam int RES_LAT = 1;
    localparam int WDOG    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [7:0]  m_in;
    logic        m_getA, m_getB, m_start, m_putOut, m_done;
    logic [15:0] m_res;

    always #5 clk = ~clk;

    radix4_mult_arbiter_if #(.NREQ(NREQ)) bus ();

    radix4_mult_arbiter #(.NREQ(NREQ), .RES_LAT(RES_LAT), .WDOG_CYC(WDOG)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .busy     (busy),
        .m_in     (m_in),
        .m_getA   (m_getA),
        .m_getB   (m_getB),
        .m_start  (m_start),
        .m_putOut (m_putOut),
        .m_done   (m_done),
        .m_res    (m_res)
    );

    // Behavioural core: done 3 cycles after start, product valid only for
    // the single cycle after putOut (garbage otherwise).
    logic [7:0] core_a, core_b;
    logic       core_run;
    int         core_cnt;
    logic       core_stuck = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_a <= '0; core_b <= '0; core_run <= 1'b0; core_cnt <= 0;
            m_done <= 1'b0; m_res <= '0;
        end else begin
            if (m_getA) core_a <= m_in;
            if (m_getB) core_b <= m_in;
            if (m_start) begin
                core_run <= 1'b1; core_cnt <= 0; m_done <= 1'b0;
            end else if (core_run && !core_stuck) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == 2) begin
                    m_done <= 1'b1; core_run <= 1'b0;
                end
            end
            if (m_putOut) begin
                m_res <= core_a * core_b; m_done <= 1'b0;
            end else begin
                m_res <= 16'hDEAD;
            end
        end
    end

    // Monitors: strobe order, bytes on m_in, and grant pulses.
    int         ev_q[$];
    int         grant_q[$];
    logic [7:0] a_seen, b_seen;

    always @(negedge clk) begin
        if (m_getA)   begin ev_q.push_back(1); a_seen = m_in; end
        if (m_getB)   begin ev_q.push_back(2); b_seen = m_in; end
        if (m_start)  ev_q.push_back(3);
        if (m_putOut) ev_q.push_back(4);
        if (bus.req_ready != '0) grant_q.push_back(int'(bus.req_ready));
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int rq);
        for (int t = 0; t < 50 && bus.req_ready == '0; t++) @(negedge clk);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << rq));
        bus.req_valid[rq] = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int cyc);
        cyc = 0;
        for (int t = 0; t < 200 && !bus.rsp_valid; t++) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic accept();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    // One isolated operation; latency counted from the grant pulse.
    task automatic do_op(input string tag, input int rq, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_res);
        int cyc;
        ev_q.delete();
        @(negedge clk);
        bus.req_a[rq*8 +: 8] = a;
        bus.req_b[rq*8 +: 8] = b;
        bus.req_valid[rq]    = 1'b1;
        wait_ready(tag, rq);
        wait_rsp(tag, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd9);
        check({tag, "_id"},  32'(bus.rsp_id), 32'(rq));
        check({tag, "_res"}, 32'(bus.rsp_res), 32'(exp_res));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        accept();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int code;
        int cyc;
        logic [15:0] exp_rr;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset with requests pending: nothing may be granted.
        bus.req_valid = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_id}, 32'd0);
        check("rst_core_bus", {19'd0, m_in, m_getA, m_getB, m_start, m_putOut, 1'b0}, 32'd0);
        bus.req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic operation and strobe ordering.
        do_op("op_0c0a", 0, 8'h0C, 8'h0A, 16'h0078);
        code = 0;
        foreach (ev_q[i]) code = code * 10 + ev_q[i];
        check("strobe_order", 32'(code), 32'd1234);
        check("m_in_a", 32'(a_seen), 32'h0C);
        check("m_in_b", 32'(b_seen), 32'h0A);

        do_op("op_005a", 0, 8'h00, 8'h5A, 16'h0000);
        do_op("op_ffff", 1, 8'hFF, 8'hFF, 16'hFE01);

        // Both requesters continuously valid: pointer is 1, so 0,1,0,1.
        grant_q.delete();
        @(negedge clk);
        bus.req_a = {8'h10, 8'h03};
        bus.req_b = {8'h20, 8'h07};
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_rsp("rr", cyc);
            exp_rr = (k % 2 == 0) ? 16'h0015 : 16'h0200;
            check($sformatf("rr%0d_id", k), 32'(bus.rsp_id), 32'(k % 2));
            check($sformatf("rr%0d_res", k), 32'(bus.rsp_res), 32'(exp_rr));
            accept();
        end
        bus.req_valid = '0;
        check("rr_grant_cnt", 32'(grant_q.size()), 32'd4);
        code = 0;
        foreach (grant_q[i]) code = code * 10 + grant_q[i];
        check("rr_grant_order", 32'(code), 32'd1212);

        // Response back-pressure for 5 cycles with another request waiting.
        grant_q.delete();
        @(negedge clk);
        bus.req_a = {8'h80, 8'h21};
        bus.req_b = {8'h02, 8'h03};
        bus.req_valid = 2'b11;
        wait_ready("hold0", 0);
        wait_rsp("hold0", cyc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("hold%0d_res", k), 32'(bus.rsp_res), 32'h0063);
            check($sformatf("hold%0d_id", k), 32'(bus.rsp_id), 32'd0);
            check($sformatf("hold%0d_ready", k), 32'(bus.req_ready), 32'd0);
        end
        check("hold_grant_cnt", 32'(grant_q.size()), 32'd1);
        accept();
        wait_ready("hold1", 1);
        wait_rsp("hold1", cyc);
        check("hold1_id", 32'(bus.rsp_id), 32'd1);
        check("hold1_res", 32'(bus.rsp_res), 32'h0100);
        accept();

        // Reset while the core is stuck in WAIT, then a fresh request.
        core_stuck = 1'b1;
        @(negedge clk);
        bus.req_a[7:0] = 8'h44;
        bus.req_b[7:0] = 8'h55;
        bus.req_valid[0] = 1'b1;
        wait_ready("rstmid", 0);
        for (int t = 0; t < 20 && !m_start; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("rstmid_busy_pre", 32'(busy), 32'd1);
        bus.req_a[15:8] = 8'h0B;
        bus.req_b[15:8] = 8'h0D;
        bus.req_valid = 2'b10;
        rst = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rsp", {13'd0, bus.rsp_res, bus.rsp_valid, bus.rsp_err, bus.rsp_id}, 32'd0);
        check("rstmid_core_bus", {19'd0, m_in, m_getA, m_getB, m_start, m_putOut, 1'b0}, 32'd0);
        @(negedge clk);
        check("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
        core_stuck = 1'b0;
        rst = 1'b1;
        wait_ready("post_rst", 1);
        wait_rsp("post_rst", cyc);
        check("post_rst_latency", 32'(cyc), 32'd9);
        check("post_rst_id", 32'(bus.rsp_id), 32'd1);
        check("post_rst_res", 32'(bus.rsp_res), 32'h008F);
        accept();

`ifdef MULT_WDOG_EN
        // Core never finishes: abort after WDOG cycles of WAIT.
        core_stuck = 1'b1;
        @(negedge clk);
        bus.req_a[7:0] = 8'h05;
        bus.req_b[7:0] = 8'h06;
        bus.req_valid[0] = 1'b1;
        wait_ready("wdog", 0);
        for (int t = 0; t < 20 && !m_start; t++) @(negedge clk);
        cyc = 0;
        for (int t = 0; t < 100 && !bus.rsp_valid; t++) begin
            @(negedge clk);
            cyc++;
        end
        check("wdog_cycles", 32'(cyc), 32'(WDOG + 1));
        check("wdog_err", 32'(bus.rsp_err), 32'd1);
        check("wdog_res", 32'(bus.rsp_res), 32'd0);
        check("wdog_id", 32'(bus.rsp_id), 32'd0);
        accept();
        core_stuck = 1'b0;
        do_op("post_wdog", 1, 8'h07, 8'h09, 16'h003F);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
